// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for alu_share_arb: opcode constants, legal-opcode check, FSM states.
package alu_share_arb_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_SHR  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_PASS = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR,
            OP_SHL, OP_SHR, OP_SRA, OP_NOR, OP_MUL, OP_PASS: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_grant.sv
// Two-requester arbiter: one-hot grant, combinational on valids; ties go to the requester not granted last.
// Build option: ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module alu_rr_grant (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 2'b01;
`else
            grant = last_grant ? 2'b01 : 2'b10;
`endif
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters; accept->response latency 2 cycles.
// Ready is offered only in IDLE; the response is held until the owner's rsp ready (tie policy: ALU_ARB_FIXED_PRIO_EN).
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_result
);

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [1:0]       grant;

    alu_rr_grant u_grant (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];

    // The ALU only ever sees the latched copies, so requesters may change inputs after accept.
    assign alu_op = op_q;
    assign alu_x  = x_q;
    assign alu_y  = y_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= 4'b0000;
            x_q        <= '0;
            y_q        <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        op_q       <= grant[1] ? req1_op : req0_op;
                        x_q        <= grant[1] ? req1_x  : req0_x;
                        y_q        <= grant[1] ? req1_y  : req0_y;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= op_legal(op_q) ? alu_result : '0;
                    rsp_err    <= !op_legal(op_q);
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural model of the shared ALU.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [3:0]  alu_op;
    logic [31:0] alu_x, alu_y, alu_result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External ALU: 1001 is modelled as a left shift by twice y; unlisted opcodes return a marker.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_op)
            4'b0000: alu_result = alu_x & alu_y;
            4'b0001: alu_result = alu_x | alu_y;
            4'b0010: alu_result = alu_x + alu_y;
            4'b0110: alu_result = alu_x - alu_y;
            4'b1001: alu_result = alu_x << {alu_y[3:0], 1'b0};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    alu_share_arb #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_op     (alu_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_result (alu_result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic o;
        resetn     = 1'b0;
        req0_valid = 1'b0; req0_op = 4'd0; req0_x = 32'd0; req0_y = 32'd0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_x = 32'd0; req1_y = 32'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step(); step();
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_x", alu_x, 0);
        chk("rst_alu_y", alu_y, 0);
        resetn = 1'b1;

        // Single add from requester 0
        req0_valid = 1'b1; req0_op = 4'b0010; req0_x = 32'd5; req0_y = 32'd7;
        #1;
        chk("t1_rdy0", req0_ready, 1);
        chk("t1_rdy1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        chk("t1_exec_rsp0", rsp0_valid, 0);
        chk("t1_alu_op", alu_op, 4'b0010);
        chk("t1_alu_x", alu_x, 5);
        chk("t1_alu_y", alu_y, 7);
        step();
        chk("t1_rsp0_valid", rsp0_valid, 1);
        chk("t1_rsp1_valid", rsp1_valid, 0);
        chk("t1_result", rsp_result, 12);
        chk("t1_err", rsp_err, 0);
        rsp0_ready = 1'b1;
        step();
        chk("t1_rsp0_done", rsp0_valid, 0);
        rsp0_ready = 1'b0;

        // Both requesters continuously valid from reset
        resetn = 1'b0; #1; resetn = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b0110; req0_x = 32'd10; req0_y = 32'd3;
        req1_valid = 1'b1; req1_op = 4'b1001; req1_x = 32'd4;  req1_y = 32'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            o = 1'b0;
`else
            o = k[0];
`endif
            #1;
            chk($sformatf("t2_rdy0_%0d", k), req0_ready, !o);
            chk($sformatf("t2_rdy1_%0d", k), req1_ready, o);
            step();
            step();
            chk($sformatf("t2_rsp0_%0d", k), rsp0_valid, !o);
            chk($sformatf("t2_rsp1_%0d", k), rsp1_valid, o);
            chk($sformatf("t2_result_%0d", k), rsp_result, o ? 32'd16 : 32'd7);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Illegal opcode from requester 1
        req1_valid = 1'b1; req1_op = 4'b0011; req1_x = 32'd9; req1_y = 32'd9;
        #1;
        chk("t3_rdy1", req1_ready, 1);
        chk("t3_rdy0", req0_ready, 0);
        step();
        req1_valid = 1'b0;
        step();
        chk("t3_rsp1_valid", rsp1_valid, 1);
        chk("t3_rsp0_valid", rsp0_valid, 0);
        chk("t3_result", rsp_result, 0);
        chk("t3_err", rsp_err, 1);
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        chk("t3_rsp1_done", rsp1_valid, 0);

        // Response backpressure with both requesters pending
        req0_valid = 1'b1; req0_op = 4'b0000; req0_x = 32'hF0; req0_y = 32'h3C;
        #1;
        chk("t4_rdy0", req0_ready, 1);
        step();
        req1_valid = 1'b1; req1_op = 4'b0010; req1_x = 32'd1; req1_y = 32'd2;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_rsp0_%0d", i), rsp0_valid, 1);
            chk($sformatf("t4_result_%0d", i), rsp_result, 32'h30);
            chk($sformatf("t4_rdy0_%0d", i), req0_ready, 0);
            chk($sformatf("t4_rdy1_%0d", i), req1_ready, 0);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        step();
        chk("t4_rsp0_done", rsp0_valid, 0);
        rsp0_ready = 1'b0;

        // Reset while an operation is executing
        req1_valid = 1'b1; req1_op = 4'b0010; req1_x = 32'd1; req1_y = 32'd1;
        #1;
        step();
        req1_valid = 1'b0;
        chk("t5_exec_op", alu_op, 4'b0010);
        resetn = 1'b0;
        #1;
        chk("t5_rst_rsp1", rsp1_valid, 0);
        chk("t5_rst_result", rsp_result, 0);
        chk("t5_rst_err", rsp_err, 0);
        chk("t5_rst_alu_op", alu_op, 0);
        chk("t5_rst_alu_x", alu_x, 0);
        chk("t5_rst_alu_y", alu_y, 0);
        step();
        resetn = 1'b1;
        step(); step();
        chk("t5_no_rsp1", rsp1_valid, 0);
        chk("t5_no_rsp0", rsp0_valid, 0);
        req0_valid = 1'b1; req0_op = 4'b0110; req0_x = 32'd20; req0_y = 32'd5;
        #1;
        chk("t5_rdy0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        step();
        chk("t5_rsp0_valid", rsp0_valid, 1);
        chk("t5_result", rsp_result, 15);
        chk("t5_err", rsp_err, 0);
        rsp0_ready = 1'b1;
        step();
        chk("t5_rsp0_done", rsp0_valid, 0);
        rsp0_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
